sr_latch_bank: RTL

Parametrised, clocked successor to the single-channel gated SR latch: a bank of `WIDTH` independent set/reset storage cells sharing one enable, with a compile-time policy for the S=R=1 case. The legacy block leaves that case undefined. Each cell also produces a registered rising-edge pulse, and the bank produces an aggregate "any set" flag. An optional saturating counter records conflict cycles for debug. The block sits between status/event sources and the interrupt/flag logic as the standard sticky-flag primitive.

---
 rtl/sr_latch_bank_pkg.sv | 35 +++
 rtl/sr_latch_bank_cell.sv | 37 +++
 rtl/sr_latch_bank.sv | 84 ++++++++
 3 files changed

// File: rtl/sr_latch_bank_pkg.sv
// Shared types, default widths and the per-cell next-state function for sr_latch_bank.
package sr_latch_bank_pkg;

    typedef enum logic [1:0] {
        SR_RESET_DOM = 2'd0,
        SR_SET_DOM   = 2'd1,
        SR_HOLD      = 2'd2,
        SR_TOGGLE    = 2'd3
    } sr_mode_e;

    localparam int SR_WIDTH_DEF = 8;
    localparam int SR_CNT_W_DEF = 8;

    function automatic logic sr_next(input logic q, input logic s, input logic r,
                                     input sr_mode_e mode);
        logic nxt;
        nxt = q;
        case ({s, r})
            2'b10:   nxt = 1'b1;
            2'b01:   nxt = 1'b0;
            2'b11: begin
                // Conflict resolution is the only place MODE matters
                case (mode)
                    SR_SET_DOM: nxt = 1'b1;
                    SR_HOLD:    nxt = q;
                    SR_TOGGLE:  nxt = ~q;
                    default:    nxt = 1'b0;
                endcase
            end
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_latch_bank_cell.sv
// One clocked set/reset storage cell with a registered rising-edge pulse.
module sr_cell
    import sr_latch_bank_pkg::*;
#(
    parameter sr_mode_e MODE = SR_RESET_DOM
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic s,
    input  logic r,
    output logic q,
    output logic rise
);

    logic q_q, q_d;
    logic rise_q, rise_d;

    always_comb begin
        q_d    = en ? sr_next(q_q, s, r, MODE) : q_q;
        rise_d = q_d & ~q_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            rise_q <= rise_d;
        end
    end

    assign q    = q_q;
    assign rise = rise_q;

endmodule

// File: rtl/sr_latch_bank.sv
// Bank of WIDTH sticky set/reset cells with conflict flag; optional saturating
// conflict counter enabled by defining SR_LATCH_BANK_CONFLICT_CNT_EN.
module sr_latch_bank
    import sr_latch_bank_pkg::*;
#(
    parameter int WIDTH = SR_WIDTH_DEF,
    parameter int MODE  = 0,
    parameter int CNT_W = SR_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
`ifdef SR_LATCH_BANK_CONFLICT_CNT_EN
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] conflict_cnt,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] rise,
    output logic             any_set,
    output logic             conflict
);

    // Out-of-range MODE falls back to reset-dominant after flagging the error
    localparam sr_mode_e EFF_MODE = (MODE < 0 || MODE > 3) ? SR_RESET_DOM : sr_mode_e'(2'(MODE));

    if (MODE < 0 || MODE > 3) begin : g_bad_mode
        $error("sr_latch_bank: illegal MODE %0d, treated as reset-dominant", MODE);
    end
    if (WIDTH < 1 || CNT_W < 2) begin : g_bad_width
        $error("sr_latch_bank: WIDTH must be >= 1 and CNT_W >= 2");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(.MODE(EFF_MODE)) u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (en),
            .s    (s[i]),
            .r    (r[i]),
            .q    (q[i]),
            .rise (rise[i])
        );
    end

    assign qbar    = ~q;
    assign any_set = |q;

    logic conflict_q, conflict_d;

    assign conflict_d = en & (|(s & r));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) conflict_q <= 1'b0;
        else        conflict_q <= conflict_d;
    end

    assign conflict = conflict_q;

`ifdef SR_LATCH_BANK_CONFLICT_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear beats increment; counting stops at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = '0;
        else if (conflict_d && cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign conflict_cnt = cnt_q;
`endif

endmodule
